// File: rtl/disp_pkg.sv
// Shared types and constants for the 4-digit multiplexed 7-segment display path.
package disp_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  typedef logic [1:0] digit_idx_t;
  typedef logic [7:0] seg_t;

  localparam seg_t       SEG_BLANK = 8'hFF;
  localparam seg_t       SEG_ZERO  = 8'h03;
  localparam logic [3:0] ANODE_OFF = 4'hF;

  // Leading-zero suppress mask; digit 1 (bit 0) is never suppressed.
  function automatic logic [NUM_DIGITS-1:0] lead_zero_mask(input seg_t d4, input seg_t d3,
                                                           input seg_t d2);
    logic [NUM_DIGITS-1:0] m;
    m    = '0;
    m[3] = (d4 == SEG_ZERO);
    m[2] = m[3] && (d3 == SEG_ZERO);
    m[1] = m[2] && (d2 == SEG_ZERO);
    return m;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Slot-rate prescaler: wraps every PRESCALE_DIV enabled cycles and flags the
// leading BLANK_CYCLES of each slot for anti-ghosting.
module scan_prescaler #(
  parameter int unsigned PRESCALE_DIV = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic slot_tick,
  output logic in_blank
);

  localparam int unsigned CW = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(PRESCALE_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == TERM) ? '0 : cnt + CW'(1);
    end
  end

  assign slot_tick = en && (cnt == TERM);

  // BLANK_CYCLES of zero removes the comparator entirely.
  if (BLANK_CYCLES == 0) begin : g_no_blank
    assign in_blank = 1'b0;
  end else begin : g_blank
    localparam logic [CW-1:0] BL = CW'(BLANK_CYCLES);
    assign in_blank = (cnt < BL);
  end

endmodule

// File: rtl/display_scan_mux.sv
// 4-digit common-anode scan multiplexer with frame-aligned shadow loading.
// Optional macro LEADING_ZERO_BLANK_EN enables leading-zero digit suppression.
module display_scan_mux
  import disp_pkg::*;
#(
  parameter int unsigned PRESCALE_DIV = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic [7:0] catodo1,
  input  logic [7:0] catodo2,
  input  logic [7:0] catodo3,
  input  logic [7:0] catodo4,
  input  logic       upd_valid,
  output logic       upd_ack,
  output logic [3:0] anodo,
  output logic [7:0] catodo,
  output logic       frame_done
);

  logic       slot_tick;
  logic       in_blank;
  logic       boundary_c;
  logic       load_c;
  logic       digit_off_c;
  digit_idx_t idx;
  seg_t       shadow [NUM_DIGITS];

  scan_prescaler #(
    .PRESCALE_DIV(PRESCALE_DIV),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_prescaler (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (en),
    .slot_tick(slot_tick),
    .in_blank (in_blank)
  );

  assign boundary_c = slot_tick && (idx == digit_idx_t'(NUM_DIGITS - 1));
  assign load_c     = boundary_c && upd_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx <= '0;
    end else if (slot_tick) begin
      idx <= idx + digit_idx_t'(1);
    end
  end

  // Shadows change only at a frame boundary so a frame never mixes digits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) shadow[i] <= SEG_ZERO;
      upd_ack    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= boundary_c;
      upd_ack    <= load_c;
      if (load_c) begin
        shadow[0] <= catodo1;
        shadow[1] <= catodo2;
        shadow[2] <= catodo3;
        shadow[3] <= catodo4;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] suppress;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      suppress <= 4'b1110;
    end else if (load_c) begin
      suppress <= lead_zero_mask(catodo4, catodo3, catodo2);
    end
  end

  assign digit_off_c = suppress[idx];
`else
  assign digit_off_c = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      anodo  <= ANODE_OFF;
      catodo <= SEG_BLANK;
    end else if (!en || in_blank || digit_off_c) begin
      anodo  <= ANODE_OFF;
      catodo <= SEG_BLANK;
    end else begin
      anodo  <= ~(4'b0001 << idx);
      catodo <= shadow[idx];
    end
  end

endmodule

// File: tb/tb_display_scan_mux.sv
// Self-checking bench for display_scan_mux with a tick-count reference model.
module tb_display_scan_mux;
  import disp_pkg::*;

  localparam int unsigned DIV   = 4;
  localparam int unsigned BLK   = 1;
  localparam int unsigned FRAME = DIV * 4;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en;
  logic [7:0] catodo1, catodo2, catodo3, catodo4;
  logic       upd_valid;
  logic       upd_ack;
  logic [3:0] anodo;
  logic [7:0] catodo;
  logic       frame_done;

  display_scan_mux #(
    .PRESCALE_DIV(DIV),
    .BLANK_CYCLES(BLK)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .catodo1   (catodo1),
    .catodo2   (catodo2),
    .catodo3   (catodo3),
    .catodo4   (catodo4),
    .upd_valid (upd_valid),
    .upd_ack   (upd_ack),
    .anodo     (anodo),
    .catodo    (catodo),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: position derived from a count of enabled cycles.
  int unsigned tick;
  logic [7:0]  msh [4];
  logic [3:0]  mmask;
  logic [3:0]  e_an;
  logic [7:0]  e_cat;
  logic        e_fd, e_ack;

  typedef struct {
    logic       en;
    logic       uv;
    logic [3:0] an;
    logic [7:0] cat;
    logic       fd;
    logic       ack;
  } vec_t;

  vec_t       tbl [18];
  logic [3:0] slot_an [4];

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    tick = 0;
    for (int i = 0; i < 4; i++) msh[i] = 8'h03;
    mmask = LZB ? 4'b1110 : 4'b0000;
  endtask

  task automatic model_load();
    logic lead;
    msh[0] = catodo1; msh[1] = catodo2; msh[2] = catodo3; msh[3] = catodo4;
    mmask = 4'b0000;
    lead  = 1'b1;
    if (LZB) begin
      for (int k = 3; k >= 1; k--) begin
        if (lead && msh[k] == 8'h03) mmask[k] = 1'b1;
        else lead = 1'b0;
      end
    end
  endtask

  task automatic model_eval();
    int unsigned ph, dg;
    ph    = tick % DIV;
    dg    = (tick / DIV) % 4;
    e_an  = 4'hF;
    e_cat = 8'hFF;
    e_fd  = 1'b0;
    e_ack = 1'b0;
    if (en) begin
      if (ph >= BLK && !mmask[dg]) begin
        e_an  = ~(4'b0001 << dg);
        e_cat = msh[dg];
      end
      if (ph == DIV - 1 && dg == 3) begin
        e_fd = 1'b1;
        if (upd_valid) begin
          e_ack = 1'b1;
          model_load();
        end
      end
      tick++;
    end
  endtask

  task automatic step(input string tag);
    model_eval();
    @(posedge clk);
    #1;
    cyc++;
    chk({tag, "/anodo"}, {4'h0, anodo}, {4'h0, e_an});
    chk({tag, "/catodo"}, catodo, e_cat);
    chk({tag, "/frame_done"}, {7'h0, frame_done}, {7'h0, e_fd});
    chk({tag, "/upd_ack"}, {7'h0, upd_ack}, {7'h0, e_ack});
  endtask

  // Steps until the pre-edge frame position equals p.
  task automatic run_to(input int unsigned p, input string tag);
    for (int g = 0; g < 64 && (tick % FRAME) != p; g++) step(tag);
  endtask

  function automatic logic [7:0] rand_seg();
    return ($urandom_range(0, 2) == 0) ? 8'h03 : 8'($urandom);
  endfunction

  task automatic chk_reset_state(input string tag);
    chk({tag, "/anodo"}, {4'h0, anodo}, 8'h0F);
    chk({tag, "/catodo"}, catodo, 8'hFF);
    chk({tag, "/frame_done"}, {7'h0, frame_done}, 8'h00);
    chk({tag, "/upd_ack"}, {7'h0, upd_ack}, 8'h00);
  endtask

  initial begin
    slot_an[0] = 4'hE;
    slot_an[1] = LZB ? 4'hF : 4'hD;
    slot_an[2] = LZB ? 4'hF : 4'hB;
    slot_an[3] = LZB ? 4'hF : 4'h7;
    for (int s = 0; s < 4; s++) begin
      for (int p = 0; p < 4; p++) begin
        tbl[4*s+p].en  = 1'b1;
        tbl[4*s+p].uv  = 1'b0;
        tbl[4*s+p].an  = (p == 0) ? 4'hF : slot_an[s];
        tbl[4*s+p].cat = (p == 0 || slot_an[s] == 4'hF) ? 8'hFF : 8'h03;
        tbl[4*s+p].fd  = (s == 3 && p == 3);
        tbl[4*s+p].ack = 1'b0;
      end
    end
    tbl[16] = '{1'b1, 1'b0, 4'hF, 8'hFF, 1'b0, 1'b0};
    tbl[17] = '{1'b1, 1'b0, 4'hE, 8'h03, 1'b0, 1'b0};

    reset_n = 1'b1; en = 1'b0; upd_valid = 1'b0;
    catodo1 = 8'h03; catodo2 = 8'h03; catodo3 = 8'h03; catodo4 = 8'h03;
    #2 reset_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk_reset_state("in_reset");

    model_reset();
    en = 1'b1;
    @(negedge clk) reset_n = 1'b1;

    // First frame after release from a fixed table.
    for (int i = 0; i < 18; i++) begin
      en = tbl[i].en;
      upd_valid = tbl[i].uv;
      model_eval();
      @(posedge clk);
      #1;
      cyc++;
      chk($sformatf("tbl%0d/anodo", i), {4'h0, anodo}, {4'h0, tbl[i].an});
      chk($sformatf("tbl%0d/catodo", i), catodo, tbl[i].cat);
      chk($sformatf("tbl%0d/frame_done", i), {7'h0, frame_done}, {7'h0, tbl[i].fd});
      chk($sformatf("tbl%0d/upd_ack", i), {7'h0, upd_ack}, {7'h0, tbl[i].ack});
    end

    // Mid-frame request, accepted at the next boundary.
    run_to(5, "pre_a");
    catodo1 = 8'h9F; catodo2 = 8'h9F; catodo3 = 8'h03; catodo4 = 8'h03;
    upd_valid = 1'b1;
    for (int g = 0; g < 2 * FRAME; g++) begin
      step("req_a");
      if (e_ack) break;
    end
    chk("ack_a", {7'h0, upd_ack}, 8'h01);
    chk("ack_a_fd", {7'h0, frame_done}, 8'h01);
    upd_valid = 1'b0;
    run_to(6, "post_a");
    step("post_a");
    chk("slot1_9f", catodo, 8'h9F);
    run_to(0, "post_a");

    // Request raised exactly on the boundary cycle.
    run_to(15, "pre_b");
    catodo1 = 8'h25; catodo2 = 8'h0D; catodo3 = 8'h99; catodo4 = 8'h49;
    upd_valid = 1'b1;
    step("bnd_b");
    chk("ack_on_boundary", {7'h0, upd_ack}, 8'h01);
    upd_valid = 1'b0;
    run_to(0, "post_b");
    run_to(0, "post_b");

    // Request dropped one cycle before the boundary.
    run_to(5, "pre_c");
    catodo1 = 8'h41; catodo2 = 8'h1F; catodo3 = 8'h01; catodo4 = 8'h09;
    upd_valid = 1'b1;
    run_to(15, "hold_c");
    upd_valid = 1'b0;
    step("bnd_c");
    chk("no_ack_after_drop", {7'h0, upd_ack}, 8'h00);
    chk("fd_after_drop", {7'h0, frame_done}, 8'h01);
    run_to(0, "post_c");
    run_to(0, "post_c");

    // Scan enable dropped for 10 cycles mid slot 2.
    run_to(9, "pre_d");
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step("en_off");
      chk("en_off_blank", {4'h0, anodo}, 8'h0F);
    end
    en = 1'b1;
    run_to(0, "resume");
    run_to(4, "resume");

    // Asynchronous reset mid slot 2 with a request pending.
    run_to(9, "pre_e");
    catodo1 = 8'h12; catodo2 = 8'h34; catodo3 = 8'h56; catodo4 = 8'h78;
    upd_valid = 1'b1;
    step("pend_e");
    #2 reset_n = 1'b0;
    #1;
    chk_reset_state("async_rst");
    model_reset();
    upd_valid = 1'b0;
    @(posedge clk); #1;
    chk_reset_state("rst_held");
    @(negedge clk) reset_n = 1'b1;
    run_to(0, "post_rst");
    run_to(0, "post_rst");
    run_to(0, "post_rst");

`ifdef LEADING_ZERO_BLANK_EN
    run_to(15, "lz1");
    catodo1 = 8'h9F; catodo2 = 8'h03; catodo3 = 8'h03; catodo4 = 8'h03;
    upd_valid = 1'b1;
    step("lz1_load");
    upd_valid = 1'b0;
    run_to(6, "lz1_run");
    step("lz1_run");
    chk("lz1_slot1_off", {4'h0, anodo}, 8'h0F);
    run_to(15, "lz2");
    catodo1 = 8'h03; catodo2 = 8'h03; catodo3 = 8'h9F; catodo4 = 8'h03;
    upd_valid = 1'b1;
    step("lz2_load");
    upd_valid = 1'b0;
    run_to(10, "lz2_run");
    step("lz2_run");
    chk("lz2_slot2_on", {4'h0, anodo}, 8'h0B);
    run_to(14, "lz2_run");
    step("lz2_run");
    chk("lz2_slot3_off", {4'h0, anodo}, 8'h0F);
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      en = ($urandom_range(0, 9) != 0);
      if (!upd_valid && $urandom_range(0, 7) == 0) begin
        catodo1 = rand_seg(); catodo2 = rand_seg();
        catodo3 = rand_seg(); catodo4 = rand_seg();
        upd_valid = 1'b1;
      end else if (upd_valid && $urandom_range(0, 39) == 0) begin
        upd_valid = 1'b0;
      end
      step("rnd");
      if (e_ack) upd_valid = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_scan_mux.md
Name: display_scan_mux

Overview:
- Downstream stage of the count-to-segment decoder; consumes its four 8-bit active-low cathode patterns (digit 1 = units … digit 4 = thousands).
- Time-multiplexes the patterns onto a 4-digit common-anode 7-segment display: one anode slot per digit, with optional inter-digit blanking.
- Loads new patterns into shadow registers only at frame boundaries, through a valid/ack handshake, so a displayed frame never mixes old and new digits.

Parameters:
- PRESCALE_DIV, 100000: clk cycles per digit slot; minimum 2; gives 1 kHz slot rate at 100 MHz.
- BLANK_CYCLES, 1000: cycles at the start of each slot with anodes off (anti-ghosting); must be < PRESCALE_DIV; 0 disables blanking.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- en  in  1  scan enable.
- catodo1..catodo4  in  8 each  segment patterns {a,b,c,d,e,f,g,dp}, active-low.
- upd_valid  in  1  request to load catodo1..4 into the shadow registers.
- upd_ack  out  1  one-cycle pulse: the shadow registers were loaded.
- anodo  out  4  digit enables, active-low; anodo[0] is digit 1.
- catodo  out  8  segment drive, active-low.
- frame_done  out  1  one-cycle pulse on each digit-3 to digit-0 wrap.

Behaviour:
- One clock domain; reset_n is asynchronous and active-low. Assertion takes effect immediately, without waiting for a clock edge.
- Reset values:
  - prescaler = 0, digit index = 0
  - anodo = 4'b1111, catodo = 8'hFF
  - upd_ack = 0, frame_done = 0
  - all shadows = 8'h03 (display reads "0000")
- Prescaler counts 0..PRESCALE_DIV-1 while en=1. At terminal count it wraps and asserts an internal slot_tick.
- On slot_tick the digit index advances 0→1→2→3→0.
- Outputs are registered; latency is 1 cycle from prescaler/index state.
  - Prescaler < BLANK_CYCLES: anodo = 1111, catodo = FF.
  - Otherwise: anodo = ~(1 << idx), catodo = shadow[idx].
- Frame boundary = slot_tick with idx == 3. frame_done pulses in the cycle after the boundary.
- Handshake:
  - upd_valid is a level signal. The source holds it, and catodo1..4, stable until upd_ack.
  - If upd_valid=1 at the boundary cycle, all four shadows load at that edge and upd_ack pulses in the next cycle, coincident with frame_done.
  - upd_valid asserted exactly on the boundary cycle is accepted.
  - Dropping upd_valid before the boundary cancels the request with no side effect.
  - At most one ack per frame.
- en=0:
  - Prescaler and index freeze; outputs blank (1111/FF) from the next cycle.
  - No boundary occurs, so no ack and no frame_done.
  - On en=1 the scan resumes from the frozen position.
- Reset mid-slot or mid-request: immediate blank; a pending request is discarded (no ack).
- Widths: prescaler width is $clog2(PRESCALE_DIV). Index is 2 bits and wraps naturally.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- Defined:
  - At shadow load, compute a 4-bit suppress mask. Digit k (k = 4,3,2) is suppressed if its pattern equals 8'h03 and every higher digit is also suppressed. Digit 1 is never suppressed.
  - Reset mask = 4'b1110.
  - In a suppressed digit's slot: anodo = 1111 and catodo = FF for the whole slot.
- Undefined: no mask logic; every digit is always driven.

Decomposition:
- Package disp_pkg:
  - SEG_BLANK = 8'hFF, SEG_ZERO = 8'h03, ANODE_OFF = 4'hF
  - NUM_DIGITS = 4
  - typedef digit_idx_t (2 bits)
  - typedef seg_t (8 bits)
- Sub-module scan_prescaler:
  - Parameters: PRESCALE_DIV, BLANK_CYCLES.
  - Inputs: clk, reset_n, en.
  - Outputs: slot_tick, in_blank.
- Top level holds the index, shadows, handshake and output registers.

Test Plan (PRESCALE_DIV=4, BLANK_CYCLES=1):
- Reset then release with en=1:
  - anodo=1111 / catodo=FF during reset.
  - After release: 1 blank cycle, then anodo=1110 / catodo=03 for 3 cycles.
  - Then 1101, 1011, 0111, each 1 blank + 3 lit cycles.
  - frame_done pulses once per 16 cycles.
- upd_valid=1 mid-frame (slot 1) with catodo1..4 = 9F,9F,03,03:
  - Outputs unchanged until the boundary.
  - upd_ack is one cycle, coincident with frame_done.
  - Next frame: slot 0 and slot 1 show 9F, slots 2 and 3 show 03.
- upd_valid raised exactly on the boundary cycle → accepted at that boundary.
- upd_valid dropped one cycle before the boundary → no ack; shadows unchanged.
- en=0 for 10 cycles mid-slot 2 → outputs blank, no frame_done. After re-enable, slot 2 completes its remaining cycles before slot 3.
- Async reset asserted mid-slot 2 with a request pending → immediate 1111/FF, shadows back to 03, no ack.
- Optionally, with LEADING_ZERO_BLANK_EN: load 9F,03,03,03 → only slot 0 lit; load 03,03,9F,03 → slot 3 blanked, slots 0–2 lit.
